load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of byte address from ALU.
REQ-002 SHALL have parameter WORD_INDEX_WIDTH, default 30, width of word index driven to data memory.
REQ-003 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port memRead  in  1  load request from Controller.
REQ-006 SHALL have port memWrite  in  1  store request from Controller.
REQ-007 SHALL have port funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port address  in  ADDR_WIDTH  byte address from ALU.
REQ-009 SHALL have port storeData  in  32  rs2 value from register file.
REQ-010 SHALL have port loadData  out  32  extended load result to writeback mux.
REQ-011 SHALL have port stall  out  1  holds PC/pipeline while a sub-word store is in progress.
REQ-012 SHALL have port misaligned  out  1  misaligned-access flag.
REQ-013 SHALL have port memAddress  out  WORD_INDEX_WIDTH  word index (address[ADDR_WIDTH-1:2]) to data memory.
REQ-014 SHALL have port memWriteData  out  32  word written to data memory.
REQ-015 SHALL have port memWriteEn / memReadEn  out  1 each  data-memory write/read strobes.
REQ-016 SHALL have port memReadData  in  32  combinational read word from data memory.

Function
REQ-017 SHALL implement FSM states IDLE and MERGE_WRITE; MERGE_WRITE is entered only from IDLE on a legal SB/SH.
REQ-018 Loads (memRead=1, memWrite=0) SHALL complete in the request cycle: memReadEn=1, byte/halfword lane selected by address[1:0], sign-extended (B,H) or zero-extended (BU,HU); W passes through; stall=0.
REQ-019 SW SHALL complete in one cycle: memWriteEn=1, memWriteData=storeData, stall=0.
REQ-020 SB/SH in IDLE SHALL assert memReadEn=1, stall=1, register word index and memReadData merged with storeData low byte/halfword in the addressed lane, then go to MERGE_WRITE.
REQ-021 In MERGE_WRITE SHALL drive registered index and merged word, memWriteEn=1, stall=0, return to IDLE; inputs ignored this cycle.
REQ-022 memWrite=1 and memRead=1 together SHALL be treated as a store; loadData=0.
REQ-023 funct3 011/110/111 SHALL be a no-op: no strobes, loadData=0, stall=0, state unchanged.
REQ-024 With no request, loadData=0 and both strobes SHALL be 0.
REQ-025 Index arithmetic SHALL drop address[1:0]; no wrap handling beyond natural truncation to WORD_INDEX_WIDTH.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, clear merge and index registers; during reset loadData=0, stall=0, misaligned=0, memWriteEn=0, memReadEn=0.
REQ-027 Reset asserted in MERGE_WRITE SHALL abort the store with no write issued.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: H/HU/SH with address[0]=1 or W/SW with address[1:0]!=0 SHALL assert misaligned=1 that cycle, suppress memWriteEn, force loadData=0, never enter MERGE_WRITE.
REQ-029 Macro undefined: misaligned SHALL be tied 0 and offending low address bits ignored (H uses address[1], W uses word).

Verification
REQ-030 Reset then mem[2]=0x8899AABB, LB address=0x0B -> loadData=0xFFFFFF88, stall=0.
REQ-031 mem[1]=0x11223344, SB storeData=0xEE address=0x05 -> cycle1 stall=1 memReadEn=1; cycle2 memWriteEn=1 memWriteData=0x1122EE44, then IDLE.
REQ-032 mem[0]=0x0000F00D, LHU address=0x00 -> 0x0000F00D; LH -> 0xFFFFF00D.
REQ-033 SH address=0x06 storeData=0x1234, reset pulsed low after cycle1 -> no memWriteEn, state IDLE, outputs 0.
REQ-034 With LSU_MISALIGN_TRAP_EN, SW address=0x02 -> misaligned=1, memWriteEn=0; without macro -> memWriteEn=1 to index 0.
REQ-035 funct3=111 with memRead=1 -> no strobes, loadData=0; memRead=memWrite=1 SW -> write occurs, loadData=0.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | load_store_unit: RV32 data-memory access with read-merge sub-word store |
// | Option: LSU_MISALIGN_TRAP_EN flags and blocks misaligned H/W accesses   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module load_store_unit #(
   parameter int ADDR_WIDTH       = 32,
   parameter int WORD_INDEX_WIDTH = 30
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        memRead,
   input  logic                        memWrite,
   input  logic [2:0]                  funct3,
   input  logic [ADDR_WIDTH-1:0]       address,
   input  logic [31:0]                 storeData,
   output logic [31:0]                 loadData,
   output logic                        stall,
   output logic                        misaligned,
   output logic [WORD_INDEX_WIDTH-1:0] memAddress,
   output logic [31:0]                 memWriteData,
   output logic                        memWriteEn,
   output logic                        memReadEn,
   input  logic [31:0]                 memReadData
);

   typedef enum logic [0:0] {
      IDLE        = 1'b0,
      MERGE_WRITE = 1'b1
   } state_t;

   state_t                      r_state;
   logic [WORD_INDEX_WIDTH-1:0] r_index;
   logic [31:0]                 r_merge;

   logic [ADDR_WIDTH-1:0]       w_addr_word;
   logic [WORD_INDEX_WIDTH-1:0] w_index;
   logic                        w_legal;
   logic                        w_size_byte;
   logic                        w_size_half;
   logic                        w_size_word;
   logic                        w_store;
   logic                        w_load;
   logic                        w_misal;
   logic                        w_start_merge;
   logic [7:0]                  w_byte;
   logic [15:0]                 w_half;
   logic [31:0]                 w_load_ext;
   logic [31:0]                 w_merged;

   assign w_addr_word = {2'b00, address[ADDR_WIDTH-1:2]};
   assign w_index     = w_addr_word[WORD_INDEX_WIDTH-1:0];

   generate
      if (WORD_INDEX_WIDTH < ADDR_WIDTH) begin : g_trunc
         logic w_unused_upper;
         assign w_unused_upper = ^w_addr_word[ADDR_WIDTH-1:WORD_INDEX_WIDTH];
      end
   endgenerate

   assign w_legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
   assign w_size_byte = (funct3[1:0] == 2'b00);
   assign w_size_half = (funct3[1:0] == 2'b01);
   assign w_size_word = (funct3[1:0] == 2'b10);
   assign w_store     = memWrite && w_legal;
   assign w_load      = memRead && !memWrite && w_legal;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misal = (w_store || w_load) &&
                    ((w_size_half && address[0]) || (w_size_word && (address[1:0] != 2'b00)));
`else
   assign w_misal = 1'b0;
`endif

   assign w_start_merge = (r_state == IDLE) && w_store && !w_size_word && !w_misal;

   always_comb begin
      w_byte = memReadData[7:0];
      case (address[1:0])
         2'b00:   w_byte = memReadData[7:0];
         2'b01:   w_byte = memReadData[15:8];
         2'b10:   w_byte = memReadData[23:16];
         default: w_byte = memReadData[31:24];
      endcase
   end

   assign w_half = address[1] ? memReadData[31:16] : memReadData[15:0];

   always_comb begin
      w_load_ext = 32'd0;
      case (funct3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b010:  w_load_ext = memReadData;
         3'b100:  w_load_ext = {24'd0, w_byte};
         3'b101:  w_load_ext = {16'd0, w_half};
         default: w_load_ext = 32'd0;
      endcase
   end

   // Splice the low store bits into the addressed lane of the current word.
   always_comb begin
      w_merged = memReadData;
      if (w_size_byte) begin
         case (address[1:0])
            2'b00:   w_merged = {memReadData[31:8], storeData[7:0]};
            2'b01:   w_merged = {memReadData[31:16], storeData[7:0], memReadData[7:0]};
            2'b10:   w_merged = {memReadData[31:24], storeData[7:0], memReadData[15:0]};
            default: w_merged = {storeData[7:0], memReadData[23:0]};
         endcase
      end else if (address[1]) begin
         w_merged = {storeData[15:0], memReadData[15:0]};
      end else begin
         w_merged = {memReadData[31:16], storeData[15:0]};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_index <= '0;
         r_merge <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_merge) begin
                  r_index <= w_index;
                  r_merge <= w_merged;
                  r_state <= MERGE_WRITE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Outputs are gated by reset so an in-flight merge never writes.
   always_comb begin
      loadData     = 32'd0;
      stall        = 1'b0;
      misaligned   = 1'b0;
      memWriteData = 32'd0;
      memWriteEn   = 1'b0;
      memReadEn    = 1'b0;
      memAddress   = (r_state == MERGE_WRITE) ? r_index : w_index;
      if (reset) begin
         if (r_state == MERGE_WRITE) begin
            memWriteEn   = 1'b1;
            memWriteData = r_merge;
         end else if (w_misal) begin
            misaligned = 1'b1;
         end else if (w_store) begin
            if (w_size_word) begin
               memWriteEn   = 1'b1;
               memWriteData = storeData;
            end else begin
               memReadEn = 1'b1;
               stall     = 1'b1;
            end
         end else if (w_load) begin
            memReadEn = 1'b1;
            loadData  = w_load_ext;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_load_store_unit: directed self-checking bench for load_store_unit    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clock;
   logic        reset;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] storeData;
   logic [31:0] loadData;
   logic        stall;
   logic        misaligned;
   logic [29:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWriteEn;
   logic        memReadEn;
   logic [31:0] memReadData;

   logic [31:0] mem [0:15];
   logic        bd_en;
   logic [3:0]  bd_idx;
   logic [31:0] bd_data;

   int checks = 0;
   int errors = 0;

   load_store_unit dut (
      .clock        (clock),
      .reset        (reset),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .funct3       (funct3),
      .address      (address),
      .storeData    (storeData),
      .loadData     (loadData),
      .stall        (stall),
      .misaligned   (misaligned),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .memWriteEn   (memWriteEn),
      .memReadEn    (memReadEn),
      .memReadData  (memReadData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Small word memory; backdoor port preloads contents.
   assign memReadData = (memAddress < 30'd16) ? mem[memAddress[3:0]] : 32'd0;

   always @(posedge clock) begin
      if (bd_en)
         mem[bd_idx] <= bd_data;
      else if (memWriteEn && (memAddress < 30'd16))
         mem[memAddress[3:0]] <= memWriteData;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd);
      memRead   = rd;
      memWrite  = wr;
      funct3    = f3;
      address   = addr;
      storeData = sd;
   endtask

   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      bd_en   = 1'b1;
      bd_idx  = idx;
      bd_data = data;
      next_cycle();
      bd_en   = 1'b0;
   endtask

   task automatic load_check(input string tag, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp);
      drive(1'b1, 1'b0, f3, addr, 32'd0);
      @(negedge clock);
      check(tag, loadData, exp);
      next_cycle();
   endtask

   initial begin
      bd_en = 1'b0; bd_idx = 4'd0; bd_data = 32'd0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      reset = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'd0);

      // Reset dominates an active load request
      #12;
      check("rst_loadData", loadData, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      check("rst_strobes", {30'd0, memWriteEn, memReadEn}, 32'd0);
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      preload(4'd2, 32'h8899AABB);
      preload(4'd1, 32'h11223344);
      preload(4'd0, 32'h0000F00D);

      @(negedge clock);
      check("idle_strobes", {30'd0, memWriteEn, memReadEn}, 32'd0);
      check("idle_loadData", loadData, 32'd0);

      // Loads
      drive(1'b1, 1'b0, 3'b000, 32'h0B, 32'd0);
      @(negedge clock);
      check("lb_0b", loadData, 32'hFFFFFF88);
      check("lb_stall", {31'd0, stall}, 32'd0);
      check("lb_rden", {31'd0, memReadEn}, 32'd1);
      next_cycle();
      load_check("lbu_0a", 3'b100, 32'h0A, 32'h00000099);
      load_check("lb_08", 3'b000, 32'h08, 32'hFFFFFFBB);
      load_check("lh_0a", 3'b001, 32'h0A, 32'hFFFF8899);
      load_check("lw_08", 3'b010, 32'h08, 32'h8899AABB);
      load_check("lhu_00", 3'b101, 32'h00, 32'h0000F00D);
      load_check("lh_00", 3'b001, 32'h00, 32'hFFFFF00D);

      // SB read-merge-write
      drive(1'b0, 1'b1, 3'b000, 32'h05, 32'h000000EE);
      @(negedge clock);
      check("sb_c1_stall", {31'd0, stall}, 32'd1);
      check("sb_c1_rden", {31'd0, memReadEn}, 32'd1);
      check("sb_c1_wren", {31'd0, memWriteEn}, 32'd0);
      next_cycle();
      drive(1'b1, 1'b0, 3'b010, 32'h08, 32'd0);
      @(negedge clock);
      check("sb_c2_wren", {31'd0, memWriteEn}, 32'd1);
      check("sb_c2_data", memWriteData, 32'h1122EE44);
      check("sb_c2_addr", {2'd0, memAddress}, 32'd1);
      check("sb_c2_stall", {31'd0, stall}, 32'd0);
      check("sb_c2_loadData", loadData, 32'd0);
      next_cycle();
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clock);
      check("sb_c3_strobes", {30'd0, memWriteEn, memReadEn}, 32'd0);
      next_cycle();
      load_check("sb_readback", 3'b010, 32'h04, 32'h1122EE44);

      // SH aborted by reset while in the write cycle
      drive(1'b0, 1'b1, 3'b001, 32'h06, 32'h00001234);
      @(negedge clock);
      check("sh_c1_stall", {31'd0, stall}, 32'd1);
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clock);
      check("sh_rst_wren", {31'd0, memWriteEn}, 32'd0);
      check("sh_rst_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      check("sh_after_strobes", {30'd0, memWriteEn, memReadEn}, 32'd0);
      next_cycle();
      load_check("sh_no_write", 3'b010, 32'h04, 32'h1122EE44);

      // SW with misaligned low bits
      drive(1'b0, 1'b1, 3'b010, 32'h02, 32'hCAFEBABE);
      @(negedge clock);
`ifdef LSU_MISALIGN_TRAP_EN
      check("sw02_misaligned", {31'd0, misaligned}, 32'd1);
      check("sw02_wren", {31'd0, memWriteEn}, 32'd0);
`else
      check("sw02_misaligned", {31'd0, misaligned}, 32'd0);
      check("sw02_wren", {31'd0, memWriteEn}, 32'd1);
      check("sw02_addr", {2'd0, memAddress}, 32'd0);
      check("sw02_data", memWriteData, 32'hCAFEBABE);
`endif
      check("sw02_stall", {31'd0, stall}, 32'd0);
      next_cycle();
`ifdef LSU_MISALIGN_TRAP_EN
      load_check("sw02_readback", 3'b010, 32'h00, 32'h0000F00D);
`else
      load_check("sw02_readback", 3'b010, 32'h00, 32'hCAFEBABE);
`endif

      // Illegal funct3 is a no-op
      drive(1'b1, 1'b0, 3'b111, 32'h08, 32'd0);
      @(negedge clock);
      check("f3_111_strobes", {30'd0, memWriteEn, memReadEn}, 32'd0);
      check("f3_111_loadData", loadData, 32'd0);
      check("f3_111_stall", {31'd0, stall}, 32'd0);
      next_cycle();

      // Read and write together behave as a store
      drive(1'b1, 1'b1, 3'b010, 32'h0C, 32'h00000055);
      @(negedge clock);
      check("rw_wren", {31'd0, memWriteEn}, 32'd1);
      check("rw_rden", {31'd0, memReadEn}, 32'd0);
      check("rw_loadData", loadData, 32'd0);
      check("rw_data", memWriteData, 32'h00000055);
      next_cycle();
      load_check("rw_readback", 3'b010, 32'h0C, 32'h00000055);

      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
